// File: rtl/victim_way_sel.sv
// victim_way_sel: pseudo-random cache victim selector.
// Prefers an invalid unlocked way; otherwise draws LFSR words until one lands
// on an unlocked way, falling back to the lowest unlocked way after MAX_DRAWS
// misses. The result is returned over a valid/ready handshake.
module victim_way_sel #(
    parameter  int NUM_WAYS   = 8,
    parameter  int RAND_WIDTH = 8,
    parameter  int MAX_DRAWS  = 4,
    localparam int WAY_W      = $clog2(NUM_WAYS)
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [RAND_WIDTH-1:0] rand_i,
    output logic                  rand_en_o,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [NUM_WAYS-1:0]   valid_ways_i,
    input  logic [NUM_WAYS-1:0]   lock_ways_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WAY_W-1:0]      rsp_way_o,
    output logic                  rsp_fallback_o,
    output logic                  rsp_none_o
);

    // Draw counter holds 0..MAX_DRAWS, so it can never wrap.
    localparam int CNT_W = $clog2(MAX_DRAWS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic [NUM_WAYS-1:0] r_valid_mask;
    logic [NUM_WAYS-1:0] r_lock_mask;
    logic [CNT_W-1:0]    r_draw_cnt;
    logic [WAY_W-1:0]    r_way;
    logic                r_fallback;
    logic                r_none;

    // Next-state / combinational signals
    state_t              w_state_next;
    logic [CNT_W-1:0]    w_draw_cnt_next;
    logic [CNT_W-1:0]    w_draw_cnt_inc;
    logic [WAY_W-1:0]    w_way_next;
    logic                w_fallback_next;
    logic                w_none_next;
    logic                w_accept;
    logic                w_rand_en;
    logic [NUM_WAYS-1:0] w_free_mask;
    logic [NUM_WAYS-1:0] w_unlocked_mask;
    logic                w_all_locked;
    logic                w_any_free;
    logic [WAY_W-1:0]    w_cand;
    logic                w_cand_locked;
    logic [WAY_W-1:0]    w_lowest_free;
    logic [WAY_W-1:0]    w_lowest_unlocked;

    // Lowest set bit index of a way mask (0 when the mask is empty).
    function automatic logic [WAY_W-1:0] f_lowest(input logic [NUM_WAYS-1:0] m);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = WAY_W'(i);
            end
        end
        return idx;
    endfunction

    // Only the low WAY_W bits of the LFSR word select a way.
    generate
        if (RAND_WIDTH > WAY_W) begin : g_rand_extra
            logic w_unused_rand;
            assign w_unused_rand = ^rand_i[RAND_WIDTH-1:WAY_W];
        end
    endgenerate

    assign w_accept          = (r_state == S_IDLE) && req_valid_i;
    assign w_unlocked_mask   = ~r_lock_mask;
    assign w_free_mask       = ~r_valid_mask & ~r_lock_mask;
    assign w_all_locked      = &r_lock_mask;
    assign w_any_free        = |w_free_mask;
    assign w_cand            = rand_i[WAY_W-1:0];
    assign w_cand_locked     = r_lock_mask[w_cand];
    assign w_lowest_free     = f_lowest(w_free_mask);
    assign w_lowest_unlocked = f_lowest(w_unlocked_mask);
    assign w_draw_cnt_inc    = r_draw_cnt + CNT_W'(1);

    // Next-state and result selection; results only move on PICK->RESP.
    always_comb begin
        w_state_next    = r_state;
        w_draw_cnt_next = r_draw_cnt;
        w_way_next      = r_way;
        w_fallback_next = r_fallback;
        w_none_next     = r_none;
        w_rand_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_state_next    = S_PICK;
                    w_draw_cnt_next = '0;
                end
            end

            S_PICK: begin
                if (w_all_locked) begin
                    // Nothing replaceable: report none with way forced to 0.
                    w_state_next    = S_RESP;
                    w_way_next      = '0;
                    w_fallback_next = 1'b0;
                    w_none_next     = 1'b1;
                end else if (w_any_free) begin
                    // An empty unlocked way beats any random choice.
                    w_state_next    = S_RESP;
                    w_way_next      = w_lowest_free;
                    w_fallback_next = 1'b0;
                    w_none_next     = 1'b0;
                end else begin
                    // Consume one LFSR word this cycle.
                    w_rand_en = 1'b1;
                    if (!w_cand_locked) begin
                        w_state_next    = S_RESP;
                        w_way_next      = w_cand;
                        w_fallback_next = 1'b0;
                        w_none_next     = 1'b0;
                    end else if (w_draw_cnt_inc == CNT_W'(MAX_DRAWS)) begin
                        // Out of draws: deterministic lowest unlocked way.
                        w_state_next    = S_RESP;
                        w_draw_cnt_next = w_draw_cnt_inc;
                        w_way_next      = w_lowest_unlocked;
                        w_fallback_next = 1'b1;
                        w_none_next     = 1'b0;
                    end else begin
                        w_draw_cnt_next = w_draw_cnt_inc;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, counter and registered response fields.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state    <= S_IDLE;
            r_draw_cnt <= '0;
            r_way      <= '0;
            r_fallback <= 1'b0;
            r_none     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_draw_cnt <= w_draw_cnt_next;
            r_way      <= w_way_next;
            r_fallback <= w_fallback_next;
            r_none     <= w_none_next;
        end
    end

    // Masks are captured only on the accept cycle and ignored afterwards.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_valid_mask <= '0;
            r_lock_mask  <= '0;
        end else if (w_accept) begin
            r_valid_mask <= valid_ways_i;
            r_lock_mask  <= lock_ways_i;
        end
    end

    assign req_ready_o    = (r_state == S_IDLE);
    assign rsp_valid_o    = (r_state == S_RESP);
    assign rand_en_o      = w_rand_en;
    assign rsp_way_o      = r_way;
    assign rsp_fallback_o = r_fallback;
    assign rsp_none_o     = r_none;

endmodule

// File: tb/tb_victim_way_sel.sv
// Testbench for victim_way_sel: directed vector table, randomized requests
// against a behavioural model, backpressure and mid-request reset sequences.
module tb_victim_way_sel;

    localparam int NW = 8;
    localparam int RW = 8;
    localparam int MD = 4;

    logic          clk;
    logic          arst_ni;
    logic [RW-1:0] rand_i;
    logic          rand_en_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [NW-1:0] valid_ways_i;
    logic [NW-1:0] lock_ways_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [2:0]    rsp_way_o;
    logic          rsp_fallback_o;
    logic          rsp_none_o;

    int checks = 0;
    int errors = 0;

    victim_way_sel #(
        .NUM_WAYS  (NW),
        .RAND_WIDTH(RW),
        .MAX_DRAWS (MD)
    ) dut (
        .clk_i         (clk),
        .arst_ni       (arst_ni),
        .rand_i        (rand_i),
        .rand_en_o     (rand_en_o),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .valid_ways_i  (valid_ways_i),
        .lock_ways_i   (lock_ways_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_way_o     (rsp_way_o),
        .rsp_fallback_o(rsp_fallback_o),
        .rsp_none_o    (rsp_none_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  valid;
        logic [7:0]  lock;
        logic [63:0] seq;     // byte k = LFSR word offered for draw k
        int          way;
        int          fb;
        int          none;
        int          draws;
        int          hold;    // cycles of rsp_ready_i low before handshake
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: rules applied directly to the masks and the word sequence.
    function automatic void model(input logic [7:0] v, input logic [7:0] l,
                                  input logic [63:0] seq,
                                  output int way, output int fb,
                                  output int none, output int draws);
        way = 0; fb = 0; none = 0; draws = 0;
        if (l == 8'hFF) begin
            none = 1;
            return;
        end
        for (int i = 0; i < NW; i++) begin
            if (!v[i] && !l[i]) begin
                way = i;
                return;
            end
        end
        for (int k = 0; k < MD; k++) begin
            int cand;
            cand  = int'(seq[8*k +: 8]) % NW;
            draws = k + 1;
            if (!l[cand]) begin
                way = cand;
                return;
            end
        end
        fb = 1;
        for (int i = 0; i < NW; i++) begin
            if (!l[i]) begin
                way = i;
                return;
            end
        end
    endfunction

    // Runs one request; entered and left about 1 time unit after a rising edge.
    task automatic run_req(input logic [7:0] v, input logic [7:0] l,
                           input logic [63:0] seq, input int ew, input int efb,
                           input int enone, input int edraws, input int hold,
                           input string tag);
        int   draws, edges, ridx, exp_lat;
        bit   got, en;
        int   w0, f0, n0;
        chk({tag, ".ready_idle"}, int'(req_ready_o), 1);
        valid_ways_i = v;
        lock_ways_i  = l;
        req_valid_i  = 1'b1;
        ridx   = 0;
        rand_i = seq[7:0];
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        valid_ways_i = 8'($urandom);
        lock_ways_i  = 8'($urandom);
        draws = 0; edges = 0; got = 1'b0;
        for (int c = 0; c < MD + 4 && !got; c++) begin
            #1;
            if (rsp_valid_o) begin
                got = 1'b1;
            end else begin
                chk({tag, ".ready_busy"}, int'(req_ready_o), 0);
                en = rand_en_o;
                if (en) draws++;
                @(posedge clk);
                edges++;
                #1;
                if (en && ridx < 7) begin
                    ridx++;
                    rand_i = seq[8*ridx +: 8];
                end
            end
        end
        chk({tag, ".rsp_seen"}, int'(got), 1);
        exp_lat = (edraws > 1) ? edraws : 1;
        chk({tag, ".latency"}, edges, exp_lat);
        chk({tag, ".draws"}, draws, edraws);
        chk({tag, ".way"}, int'(rsp_way_o), ew);
        chk({tag, ".fallback"}, int'(rsp_fallback_o), efb);
        chk({tag, ".none"}, int'(rsp_none_o), enone);
        chk({tag, ".rand_en_resp"}, int'(rand_en_o), 0);
        w0 = int'(rsp_way_o); f0 = int'(rsp_fallback_o); n0 = int'(rsp_none_o);
        for (int h = 0; h < hold; h++) begin
            rand_i = 8'($urandom);
            @(posedge clk);
            #1;
            chk({tag, ".bp_valid"}, int'(rsp_valid_o), 1);
            chk({tag, ".bp_ready"}, int'(req_ready_o), 0);
            chk({tag, ".bp_rand_en"}, int'(rand_en_o), 0);
            chk({tag, ".bp_way"}, int'(rsp_way_o), w0);
            chk({tag, ".bp_fb"}, int'(rsp_fallback_o), f0);
            chk({tag, ".bp_none"}, int'(rsp_none_o), n0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        chk({tag, ".idle_ready"}, int'(req_ready_o), 1);
        chk({tag, ".idle_valid"}, int'(rsp_valid_o), 0);
        chk({tag, ".idle_way_held"}, int'(rsp_way_o), w0);
        $display("%s: valid=%02h lock=%02h way=%0d fb=%0d none=%0d draws=%0d lat=%0d hold=%0d",
                 tag, v, l, w0, f0, n0, draws, edges, hold);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_ready"}, int'(req_ready_o), 1);
        chk({tag, ".rsp_valid"}, int'(rsp_valid_o), 0);
        chk({tag, ".rand_en"}, int'(rand_en_o), 0);
        chk({tag, ".way"}, int'(rsp_way_o), 0);
        chk({tag, ".fb"}, int'(rsp_fallback_o), 0);
        chk({tag, ".none"}, int'(rsp_none_o), 0);
    endtask

    initial begin
        int ew, efb, en, ed;
        logic [7:0]  v, l;
        logic [63:0] seq;

        //          valid   lock    seq (byte0 first)        way fb none draws hold
        vecs[0] = '{8'hFB, 8'h00, 64'h0,                  2, 0, 0, 0, 0};
        vecs[1] = '{8'hFF, 8'h0F, 64'h25,                 5, 0, 0, 1, 0};
        vecs[2] = '{8'hFF, 8'h7F, 64'h04030201,           7, 1, 0, 4, 0};
        vecs[3] = '{8'hFF, 8'hFF, 64'h0,                  0, 0, 1, 0, 0};
        vecs[4] = '{8'hFF, 8'h0F, 64'h06,                 6, 0, 0, 1, 10};
        vecs[5] = '{8'hFF, 8'hFE, 64'h0813,               0, 0, 0, 2, 1};
        vecs[6] = '{8'h7F, 8'h80, 64'h090F,               1, 0, 0, 2, 2};
        vecs[7] = '{8'h00, 8'hFF, 64'h0,                  0, 0, 1, 0, 0};
        vecs[8] = '{8'hFF, 8'hF7, 64'h04020100,           3, 1, 0, 4, 3};

        arst_ni      = 1'b0;
        rand_i       = '0;
        req_valid_i  = 1'b0;
        valid_ways_i = '0;
        lock_ways_i  = '0;
        rsp_ready_i  = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #3;
        arst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i].valid, vecs[i].lock, vecs[i].seq, vecs[i].way,
                    vecs[i].fb, vecs[i].none, vecs[i].draws, vecs[i].hold,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       v = 8'($urandom);
                default: v = 8'hFF;
            endcase
            case ($urandom_range(0, 5))
                0:       l = 8'hFF;
                1:       l = 8'($urandom) | 8'hF0;
                2:       l = 8'hFF & ~(8'h01 << $urandom_range(0, 7));
                default: l = 8'($urandom);
            endcase
            seq = {$urandom, $urandom};
            model(v, l, seq, ew, efb, en, ed);
            run_req(v, l, seq, ew, efb, en, ed, $urandom_range(0, 3),
                    $sformatf("rnd%0d", i));
        end

        // Leave a nonzero way registered so the reset clearing it is visible.
        run_req(8'hFF, 8'h0F, 64'h25, 5, 0, 0, 1, 0, "pre_reset");

        // Reset in the middle of a draw sequence.
        valid_ways_i = 8'hFF;
        lock_ways_i  = 8'h7F;
        rand_i       = 8'h01;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rand_i      = 8'h02;
        @(posedge clk);
        #1;
        chk("midpick.drawing", int'(rand_en_o), 1);
        #2;
        arst_ni = 1'b0;
        #1;
        chk_reset_vals("midpick_rst");
        @(posedge clk);
        #3;
        arst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("after_rst");
        run_req(8'hFF, 8'h0F, 64'h25, 5, 0, 0, 1, 0, "fresh");

        // Reset while held in the response state.
        valid_ways_i = 8'hFB;
        lock_ways_i  = 8'h00;
        req_valid_i  = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midresp.valid", int'(rsp_valid_o), 1);
        #2;
        arst_ni = 1'b0;
        #1;
        chk_reset_vals("midresp_rst");
        @(posedge clk);
        #3;
        arst_ni = 1'b1;
        @(posedge clk);
        #1;
        run_req(8'hFF, 8'h7F, 64'h04030201, 7, 1, 0, 4, 0, "fresh2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
